// File: rtl/xy_scope_pkg.sv
// Shared definitions for the XY oscilloscope figure generator: figure modes,
// the quarter-turn phase constant and the quarter-wave sine table generator.
package xy_scope_pkg;

    typedef enum logic [1:0] {
        MODE_LISSAJOUS = 2'b00,
        MODE_SWEEP     = 2'b01,
        MODE_CIRCLE    = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    // Quadrant-field value of a quarter turn; placed in the top two phase bits.
    localparam logic [1:0] QUARTER_PHASE = 2'b01;

    localparam real PI = 3.14159265358979323846;

    // Sample points sit mid-bin so the fold is symmetric about each quadrant edge.
    function automatic int lut_entry(input int x_w, input int lut_aw, input int k);
        real amp;
        real ang;
        amp = (2.0 ** (x_w - 1)) - 1.0;
        ang = (k + 0.5) * PI / (2.0 ** (lut_aw + 1));
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/xy_sine_fold.sv
// One axis of the XY generator: quadrant fold and table index in stage 1,
// table read and offset-binary code (or raw bypass code) in stage 2.
module xy_sine_fold
    import xy_scope_pkg::*;
#(
    parameter int W      = 8,
    parameter int X_W    = 8,
    parameter int LUT_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load1,
    input  logic              load2,
    input  logic [LUT_AW+1:0] phase_msb,
    input  logic              raw_sel,
    input  logic [W-1:0]      raw_code,
    output logic [W-1:0]      code
);

    localparam int LUT_N = 2 ** LUT_AW;
    localparam int SHIFT = X_W - W;
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    function automatic logic [LUT_N*X_W-1:0] build_lut();
        logic [LUT_N*X_W-1:0] t;
        t = '0;
        for (int k = 0; k < LUT_N; k++) begin
            t[k*X_W +: X_W] = X_W'(lut_entry(X_W, LUT_AW, k));
        end
        return t;
    endfunction

    localparam logic [LUT_N*X_W-1:0] LUT = build_lut();

    logic [1:0]        quad;
    logic [LUT_AW-1:0] idx;
    logic [1:0]        quad_q;
    logic [LUT_AW-1:0] idx_q;
    logic              raw_q;
    logic [W-1:0]      raw_code_q;
    logic [X_W-1:0]    m_full;
    logic [W-1:0]      m;
    logic [W-1:0]      code_nxt;

    assign quad = phase_msb[LUT_AW+1 -: 2];
    assign idx  = quad[0] ? ~phase_msb[LUT_AW-1:0] : phase_msb[LUT_AW-1:0];

    // Narrower axes reuse the full-width table scaled down by a right shift.
    always_comb begin
        m_full   = LUT[idx_q*X_W +: X_W];
        m        = W'(m_full >> SHIFT);
        code_nxt = quad_q[1] ? (HALF - W'(1) - m) : (HALF + m);
        if (raw_q) begin
            code_nxt = raw_code_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quad_q     <= '0;
            idx_q      <= '0;
            raw_q      <= 1'b0;
            raw_code_q <= '0;
            code       <= '0;
        end else begin
            if (load1) begin
                quad_q     <= quad;
                idx_q      <= idx;
                raw_q      <= raw_sel;
                raw_code_q <= raw_code;
            end
            if (load2) begin
                code <= code_nxt;
            end
        end
    end

endmodule

// File: rtl/xy_scope_gen.sv
// XY oscilloscope figure generator: prescaled dual phase accumulators feeding
// two sine-fold pipelines. Define XY_ZBLANK_EN to add the z_blank retrace output.
module xy_scope_gen
    import xy_scope_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 5,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   div,
    input  logic [PHASE_W-1:0] fx_inc,
    input  logic [PHASE_W-1:0] fy_inc,
    input  logic [PHASE_W-1:0] phase_off,
    output logic [X_W-1:0]     bnc_x,
    output logic [Y_W-1:0]     bnc_y,
    output logic               sample_stb,
`ifdef XY_ZBLANK_EN
    output logic               z_blank,
`endif
    output logic               trig
);

    mode_e              mode_sel;
    logic [DIV_W-1:0]   cnt;
    logic               tick;
    logic               sample_tick;
    logic               load2;
    logic [PHASE_W-1:0] ph_x;
    logic [PHASE_W-1:0] ph_y;
    logic [PHASE_W:0]   ph_x_sum;
    logic [PHASE_W-1:0] ph_x_nxt;
    logic [PHASE_W-1:0] ph_y_nxt;
    logic [PHASE_W-1:0] y_phase;
    logic               v1;
    logic               wrap1;
    logic               sweep1;
    logic               unused_phase_bits;

    assign mode_sel    = mode_e'(mode);
    assign tick        = en && (cnt >= div);
    assign sample_tick = tick && (mode_sel != MODE_HOLD);
    assign load2       = en && v1;

    assign ph_x_sum = {1'b0, ph_x} + {1'b0, fx_inc};
    assign ph_x_nxt = ph_x_sum[PHASE_W-1:0];
    assign ph_y_nxt = ph_y + fy_inc;

    // Circle derives Y from the X phase a quarter turn ahead; ph_y keeps running regardless.
    always_comb begin
        y_phase = ph_y_nxt + phase_off;
        if (mode_sel == MODE_CIRCLE) begin
            y_phase = ph_x_nxt + {QUARTER_PHASE, {(PHASE_W-2){1'b0}}} + phase_off;
        end
    end

    assign unused_phase_bits = ^y_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            ph_x       <= '0;
            ph_y       <= '0;
            v1         <= 1'b0;
            wrap1      <= 1'b0;
            sweep1     <= 1'b0;
            sample_stb <= 1'b0;
            trig       <= 1'b0;
`ifdef XY_ZBLANK_EN
            z_blank    <= 1'b0;
`endif
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            v1  <= sample_tick;
            if (sample_tick) begin
                ph_x   <= ph_x_nxt;
                ph_y   <= ph_y_nxt;
                wrap1  <= ph_x_sum[PHASE_W];
                sweep1 <= (mode_sel == MODE_SWEEP);
            end
            sample_stb <= v1;
            trig       <= v1 && wrap1;
`ifdef XY_ZBLANK_EN
            z_blank    <= v1 && wrap1 && sweep1;
`endif
        end else begin
            sample_stb <= 1'b0;
            trig       <= 1'b0;
`ifdef XY_ZBLANK_EN
            z_blank    <= 1'b0;
`endif
        end
    end

    xy_sine_fold #(
        .W      (X_W),
        .X_W    (X_W),
        .LUT_AW (LUT_AW)
    ) u_fold_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .load1     (sample_tick),
        .load2     (load2),
        .phase_msb (ph_x_nxt[PHASE_W-1 -: LUT_AW+2]),
        .raw_sel   (mode_sel == MODE_SWEEP),
        .raw_code  (ph_x_nxt[PHASE_W-1 -: X_W]),
        .code      (bnc_x)
    );

    xy_sine_fold #(
        .W      (Y_W),
        .X_W    (X_W),
        .LUT_AW (LUT_AW)
    ) u_fold_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .load1     (sample_tick),
        .load2     (load2),
        .phase_msb (y_phase[PHASE_W-1 -: LUT_AW+2]),
        .raw_sel   (1'b0),
        .raw_code  ({Y_W{1'b0}}),
        .code      (bnc_y)
    );

endmodule

// File: tb/tb_xy_scope_gen.sv
// Directed self-checking bench for xy_scope_gen with hand-computed expected codes.
`timescale 1ns/1ps
module tb_xy_scope_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  div;
    logic [15:0] fx_inc;
    logic [15:0] fy_inc;
    logic [15:0] phase_off;
    logic [7:0]  bnc_x;
    logic [6:0]  bnc_y;
    logic        sample_stb;
    logic        trig;
`ifdef XY_ZBLANK_EN
    logic        z_blank;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xy_scope_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .div        (div),
        .fx_inc     (fx_inc),
        .fy_inc     (fy_inc),
        .phase_off  (phase_off),
        .bnc_x      (bnc_x),
        .bnc_y      (bnc_y),
        .sample_stb (sample_stb),
`ifdef XY_ZBLANK_EN
        .z_blank    (z_blank),
`endif
        .trig       (trig)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic waitStb(input string tag, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!sample_stb && cycles < 64);
        if (!sample_stb) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Load a configuration and restart the generator from a clean reset.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d,
                                 input logic [15:0] fx, input logic [15:0] fy,
                                 input logic [15:0] off);
        mode      = m;
        div       = d;
        fx_inc    = fx;
        fy_inc    = fy;
        phase_off = off;
        en        = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int trig_count;
        int first_trig;
        int x_at_trig;
        int stb_count;
        int qx[4]  = '{255, 124, 0, 131};
        int sx[4]  = '{64, 128, 192, 0};
        int cx[4]  = '{255, 124, 0, 131};
        int cy[4]  = '{62, 0, 65, 127};

        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 2'b00;
        div       = 8'd0;
        fx_inc    = 16'd0;
        fy_inc    = 16'd0;
        phase_off = 16'd0;
        repeat (3) step();
        checkOutput("reset_x", bnc_x, 0);
        checkOutput("reset_y", bnc_y, 0);
        checkOutput("reset_stb", sample_stb, 0);
        checkOutput("reset_trig", trig, 0);

        rst_n = 1'b1;
        en    = 1'b1;
        step();
        checkOutput("latency_no_stb_yet", sample_stb, 0);
        step();
        checkOutput("latency_stb", sample_stb, 1);
        checkOutput("latency_x", bnc_x, 131);
        checkOutput("latency_y", bnc_y, 65);
        checkOutput("latency_trig", trig, 0);

        applyStimulus(2'b00, 8'd0, 16'h4000, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            waitStb("quad", cyc);
            checkOutput("quad_gap", cyc, (i == 0) ? 2 : 1);
            checkOutput("quad_x", bnc_x, qx[i % 4]);
            checkOutput("quad_y", bnc_y, 65);
            checkOutput("quad_trig", trig, (i % 4 == 3) ? 1 : 0);
        end

        applyStimulus(2'b00, 8'd0, 16'h0200, 16'h0000, 16'h0000);
        trig_count = 0;
        first_trig = 0;
        x_at_trig  = 0;
        for (int n = 1; n <= 256; n++) begin
            waitStb("trigper", cyc);
            if (trig) begin
                trig_count++;
                if (first_trig == 0) begin
                    first_trig = n;
                    x_at_trig  = int'(bnc_x);
                end
            end
        end
        checkOutput("trig_count", trig_count, 2);
        checkOutput("trig_first_index", first_trig, 128);
        checkOutput("trig_x", x_at_trig, 131);

        applyStimulus(2'b00, 8'd0, 16'h0000, 16'h0000, 16'h4000);
        waitStb("offset", cyc);
        checkOutput("offset_x", bnc_x, 131);
        checkOutput("offset_y", bnc_y, 127);

        applyStimulus(2'b01, 8'd0, 16'h4000, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            waitStb("sweep", cyc);
            checkOutput("sweep_x", bnc_x, sx[i]);
            checkOutput("sweep_y", bnc_y, 65);
            checkOutput("sweep_trig", trig, (i == 3) ? 1 : 0);
        end

        applyStimulus(2'b10, 8'd0, 16'h4000, 16'h1234, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            waitStb("circle", cyc);
            checkOutput("circle_x", bnc_x, cx[i]);
            checkOutput("circle_y", bnc_y, cy[i]);
        end
        mode      = 2'b11;
        stb_count = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (sample_stb) stb_count++;
        end
        checkOutput("hold_inflight_stb", stb_count, 1);
        checkOutput("hold_stb_low", sample_stb, 0);
        checkOutput("hold_x", bnc_x, 255);
        checkOutput("hold_y", bnc_y, 62);

        applyStimulus(2'b00, 8'd3, 16'h0000, 16'h0000, 16'h0000);
        waitStb("div3", cyc);
        checkOutput("div3_first", cyc, 5);
        waitStb("div3", cyc);
        checkOutput("div3_period_a", cyc, 4);
        waitStb("div3", cyc);
        checkOutput("div3_period_b", cyc, 4);

        applyStimulus(2'b00, 8'd9, 16'h0000, 16'h0000, 16'h0000);
        stb_count = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sample_stb) stb_count++;
        end
        checkOutput("div9_no_stb", stb_count, 0);
        div = 8'd1;
        waitStb("div_drop", cyc);
        checkOutput("div_drop_first", cyc, 2);
        waitStb("div_drop", cyc);
        checkOutput("div_drop_period_a", cyc, 2);
        waitStb("div_drop", cyc);
        checkOutput("div_drop_period_b", cyc, 2);

        applyStimulus(2'b00, 8'd0, 16'h4000, 16'h0000, 16'h0000);
        waitStb("en", cyc);
        checkOutput("en_first_x", bnc_x, 255);
        en        = 1'b0;
        stb_count = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (sample_stb || trig) stb_count++;
        end
        checkOutput("en_low_quiet", stb_count, 0);
        checkOutput("en_low_x_held", bnc_x, 255);
        en = 1'b1;
        waitStb("en_resume", cyc);
        checkOutput("en_resume_gap", cyc, 1);
        checkOutput("en_resume_x", bnc_x, 124);

        rst_n = 1'b0;
        step();
        checkOutput("midrst_x", bnc_x, 0);
        checkOutput("midrst_y", bnc_y, 0);
        checkOutput("midrst_stb", sample_stb, 0);
        checkOutput("midrst_trig", trig, 0);
        rst_n = 1'b1;
        step();
        checkOutput("midrst_no_stale", sample_stb, 0);
        step();
        checkOutput("midrst_fresh_stb", sample_stb, 1);
        checkOutput("midrst_fresh_x", bnc_x, 255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
